dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
- Sequences and shares the single 256x8 data memory between two requesters: port 0 is the CPU MEM stage (lw/sw), port 1 is the debug/loader port.
- The memory samples its controls on every change of its `mem_stage` input. This block therefore owns `mem_stage` and `MemRead`/`MemWrite`/address/write-data, and guarantees they are stable before each toggle.
- It sits between the pipeline MEM stage and `memory_block`, and returns read data plus a completion pulse to the winning requester.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- SETTLE_CYCLES, 1, cycles spent in WAIT after the toggle before read data is captured (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  2  per-port request, bit0 = CPU, bit1 = debug.
- we_i  input  2  per-port write enable; 1 = sw, 0 = lw.
- addr0_i / addr1_i  input  ADDR_W each  per-port address.
- wdata0_i / wdata1_i  input  DATA_W each  per-port store data.
- gnt_o  output  2  one-hot, one-cycle accept pulse.
- done_o  output  2  one-hot, one-cycle completion pulse.
- rdata_o  output  DATA_W  captured read data, valid with done_o on a read.
- busy_o  output  1  high whenever state != IDLE.
- mem_stage_o  output  1  toggles once per access; drives `memory_block.mem_stage`.
- mem_read_o / mem_write_o  output  1 each  drive MemRead / MemWrite.
- mem_addr_o  output  ADDR_W  drives ALUresult_mem_address.
- mem_wdata_o  output  DATA_W  drives write_to_mem_data.
- mem_data_i  input  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: state = IDLE; gnt_o, done_o, rdata_o, busy_o, mem_stage_o, mem_read_o, mem_write_o, mem_addr_o and mem_wdata_o all 0; last_grant = 1 (so the CPU wins the first tie).
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE: if any req_i bit is set at a clock edge, pick a winner. A single requester wins outright. If both request, the port != last_grant wins (round-robin). At that edge:
  - latch the winner's addr, wdata and we into mem_addr_o, mem_wdata_o and mem_write_o;
  - set mem_read_o = ~we;
  - pulse the winner's gnt_o bit;
  - update last_grant and go to ISSUE.
- ISSUE (1 cycle): memory controls are held stable. On exit edge, mem_stage_o inverts and gnt_o clears. Go to WAIT.
- WAIT: a counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. When it is 0, go to DONE. rdata_o captures mem_data_i at that edge, but only on a read; on a write rdata_o holds its previous value.
- DONE (1 cycle): the winner's done_o bit is high. mem_read_o and mem_write_o are cleared on entry. Address and write data hold their values. Next edge returns to IDLE.
- Latency: req seen at edge E gives gnt_o high in cycle E+1 and done_o high in cycle E+2+SETTLE_CYCLES. A single access is therefore 3+SETTLE_CYCLES cycles from req to the end of done; the default is 4.
- Requester rules:
  - Hold req, addr, wdata and we stable until gnt is seen.
  - Inputs are sampled only at the accept edge; changes after that are ignored.
  - If req is still high in the DONE cycle, that is a new request.
- req_i arriving while busy is not accepted. It is re-evaluated in the next IDLE; nothing is queued.
- Back-to-back: one IDLE cycle always separates transactions. Under continuous dual requests the ports alternate strictly: 0, 1, 0, 1, ...
- mem_stage_o toggles exactly once per transaction, never in IDLE. Its value is the parity of the number of completed issues.
- Reset mid-transaction (any state): return to reset values immediately and drop the in-flight access with no done pulse. A write whose toggle already occurred has taken effect in memory; one still in ISSUE has not.
- Invariants:
  - gnt_o and done_o are one-hot or zero.
  - mem_read_o and mem_write_o are never both 1.

Decomposition:
- Shared package `dmem_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - port index constants PORT_CPU = 0, PORT_DBG = 1;
  - ADDR_W and DATA_W defaults.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from req[1:0] and last_grant. Outputs a one-hot grant and a valid flag.

Test Plan:
- Reset release, CPU read addr 8'h05 -> gnt_o = 01 in cycle 1; mem_stage_o toggles 0->1; done_o = 01 in cycle 3 with rdata_o = 8'h0A (memory is initialised to mem[i] = 2i).
- CPU write addr 8'h10, data 8'h77, then debug read 8'h10 -> write done with mem_write_o high during ISSUE/WAIT; debug done carries rdata_o = 8'h77.
- Both ports request continuously for 4 transactions -> grant order 0, 1, 0, 1; one IDLE cycle between each; busy_o low only in those cycles.
- Debug request raised while CPU access is in WAIT -> no gnt_o until IDLE; debug then granted; CPU access completes unaffected.
- rst_n asserted during WAIT of a read -> all outputs 0 asynchronously; no done_o after release; next request starts with mem_stage_o = 0 and toggles to 1.
- SETTLE_CYCLES = 3, CPU read addr 8'hFF -> done_o in cycle 5; rdata_o = 8'hFE (2x255 truncated to 8 bits).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory access arbiter
//
// Contents:
//   state_t      : sequencer states IDLE -> ISSUE -> WAIT -> DONE
//   PORT_CPU/DBG : requester indices into req/we/gnt/done vectors
//   ADDR_W_DEF   : default memory address width
//   DATA_W_DEF   : default memory data width
//   CNT_W        : width of the settle counter (SETTLE_CYCLES up to 15)
//   port_onehot  : index -> one-hot port vector
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_access_arbiter_rr.sv
// rtl/dmem_access_arbiter_rr.sv - combinational two-way round-robin pick
//
// Ports:
//   req        in  [1:0] per-port request
//   last_grant in        index of the port granted most recently
//   grant      out [1:0] one-hot winner (zero when no request)
//   valid      out       a winner exists
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[PORT_CPU] = 1'b1;
            2'b10:   grant[PORT_DBG] = 1'b1;
            // Tie goes to the port that did not win last time.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        valid = |req;
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - shares one toggle-sampled data memory between CPU and debug ports
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i, we_i                per-port request and write enable (bit0 CPU, bit1 debug)
//   addr0_i/addr1_i            per-port address
//   wdata0_i/wdata1_i          per-port store data
//   gnt_o, done_o              one-hot accept / completion pulses
//   rdata_o                    captured read data, valid with done_o on a read
//   busy_o                     high whenever the sequencer is not idle
//   mem_stage_o                toggles once per access; the memory samples on each change
//   mem_read_o, mem_write_o    memory read / write strobes
//   mem_addr_o, mem_wdata_o    memory address / write data
//   mem_data_i                 memory read data
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              mem_stage_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               port_q, port_d;

    logic [1:0]         gnt_d, done_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               busy_d, mem_stage_d, mem_read_d, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;

    logic [1:0]         pick;
    logic               pick_valid;
    logic               pick_port;

    rr_arbiter2 u_rr (
        .req        (req_i),
        .last_grant (last_grant_q),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign pick_port = pick[PORT_DBG];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        rdata_d      = rdata_o;
        mem_stage_d  = mem_stage_o;
        mem_read_d   = mem_read_o;
        mem_write_d  = mem_write_o;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    mem_addr_d   = pick_port ? addr1_i  : addr0_i;
                    mem_wdata_d  = pick_port ? wdata1_i : wdata0_i;
                    mem_write_d  = we_i[pick_port];
                    mem_read_d   = ~we_i[pick_port];
                    gnt_d        = pick;
                    last_grant_d = pick_port;
                    port_d       = pick_port;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Controls have been stable for a full cycle; the memory samples now.
                mem_stage_d = ~mem_stage_o;
                cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (mem_read_o) begin
                        rdata_d = mem_data_i;
                    end
                    done_d      = port_onehot(port_q);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            gnt_o        <= 2'b00;
            done_o       <= 2'b00;
            rdata_o      <= '0;
            busy_o       <= 1'b0;
            mem_stage_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            gnt_o        <= gnt_d;
            done_o       <= done_d;
            rdata_o      <= rdata_d;
            busy_o       <= busy_d;
            mem_stage_o  <= mem_stage_d;
            mem_read_o   <= mem_read_d;
            mem_write_o  <= mem_write_d;
            mem_addr_o   <= mem_addr_d;
            mem_wdata_o  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb/tb_dmem_access_arbiter.sv - scoreboard testbench for dmem_access_arbiter
module tb_dmem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata, mem_addr, mem_wdata;
    logic       busy, mem_stage, mem_read, mem_write;
    logic [7:0] mem_data = 8'h00;

    logic [1:0] req3, we3;
    logic [7:0] addr3, addr3b, wdata3, wdata3b;
    logic [1:0] gnt3, done3;
    logic [7:0] rdata3, mem_addr3, mem_wdata3;
    logic       busy3, mem_stage3, mem_read3, mem_write3;
    logic [7:0] mem_data3 = 8'h00;

    dmem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
        .mem_stage_o(mem_stage), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_data_i(mem_data)
    );

    dmem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we3),
        .addr0_i(addr3), .addr1_i(addr3b), .wdata0_i(wdata3), .wdata1_i(wdata3b),
        .gnt_o(gnt3), .done_o(done3), .rdata_o(rdata3), .busy_o(busy3),
        .mem_stage_o(mem_stage3), .mem_read_o(mem_read3), .mem_write_o(mem_write3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_data_i(mem_data3)
    );

    // Memory models: sample controls on each change of mem_stage.
    logic [7:0] mem  [256];
    logic [7:0] mem3 [256];
    logic [7:0] ref_mem [256];

    always @(mem_stage) begin
        if (mem_write) mem[mem_addr] = mem_wdata;
        if (mem_read)  mem_data = mem[mem_addr];
    end

    always @(mem_stage3) begin
        if (mem_write3) mem3[mem_addr3] = mem_wdata3;
        if (mem_read3)  mem_data3 = mem3[mem_addr3];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] port_oh;
        logic       is_read;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int port, input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.port_oh = (port == 1) ? 2'b10 : 2'b01;
        e.is_read = !w;
        e.rdata   = ref_mem[a];
        if (w) ref_mem[a] = d;
        sb.push_back(e);
    endtask

    // Scoreboard monitor and invariants for the SETTLE_CYCLES=1 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(gnt) > 1 || $countones(done) > 1 || (mem_read && mem_write)) begin
                errors++;
                $display("FAIL invariant gnt=%b done=%b rd=%b wr=%b want onehot0 and not both", gnt, done, mem_read, mem_write);
            end
            if (done != 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done got done=%b want no completion", done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (done !== e.port_oh) begin
                        errors++;
                        $display("FAIL sb_done_port got %b want %b", done, e.port_oh);
                    end
                    if (e.is_read) begin
                        checks++;
                        if (rdata !== e.rdata) begin
                            errors++;
                            $display("FAIL sb_rdata got %h want %h", rdata, e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, done, rdata, busy, mem_stage, mem_read, mem_write, mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {gnt, done, rdata, busy, mem_stage, mem_read, mem_write, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_cpu_read;
        rst_n = 1'b1;
        req = 2'b01; we = 2'b00; addr0 = 8'h05;
        push_exp(0, 1'b0, 8'h05, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b01 || mem_stage !== 1'b0 || mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_accept got gnt=%b stage=%b rd=%b busy=%b want 01 0 1 1", gnt, mem_stage, mem_read, busy);
        end
        req = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (mem_stage !== 1'b1 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL read_toggle got stage=%b gnt=%b want 1 00", mem_stage, gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 2'b01 || rdata !== 8'h0A) begin
            errors++;
            $display("FAIL read_done got done=%b rdata=%h want 01 0a", done, rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            errors++;
            $display("FAIL read_idle got busy=%b done=%b want 0 00", busy, done);
        end
    endtask

    task automatic test_write_then_read;
        bit ok;
        req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'h77;
        push_exp(0, 1'b1, 8'h10, 8'h77);
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b01 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL write_issue got gnt=%b wr=%b rd=%b want 01 1 0", gnt, mem_write, mem_read);
        end
        req = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h77) begin
            errors++;
            $display("FAIL write_wait got wr=%b addr=%h wdata=%h want 1 10 77", mem_write, mem_addr, mem_wdata);
        end
        wait_done(ok);
        checks++;
        if (!ok || done !== 2'b01 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL write_done got ok=%0d done=%b wr=%b want 1 01 0", ok, done, mem_write);
        end
        @(posedge clk); #1;
        req = 2'b10; we = 2'b00; addr1 = 8'h10;
        push_exp(1, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL dbg_accept got gnt=%b want 10", gnt);
        end
        req = 2'b00;
        wait_done(ok);
        checks++;
        if (!ok || done !== 2'b10 || rdata !== 8'h77) begin
            errors++;
            $display("FAIL dbg_readback got ok=%0d done=%b rdata=%h want 1 10 77", ok, done, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        int order[$];
        int ndone;
        int idle;
        req = 2'b11; we = 2'b00; addr0 = 8'h21; addr1 = 8'h42;
        push_exp(0, 1'b0, 8'h21, 8'h00);
        push_exp(1, 1'b0, 8'h42, 8'h00);
        push_exp(0, 1'b0, 8'h21, 8'h00);
        push_exp(1, 1'b0, 8'h42, 8'h00);
        ndone = 0;
        idle  = 0;
        for (int i = 0; i < 40 && ndone < 4; i++) begin
            @(posedge clk); #1;
            if (gnt == 2'b01) order.push_back(0);
            if (gnt == 2'b10) order.push_back(1);
            if (done != 2'b00) ndone++;
            if (order.size() > 0 && busy == 1'b0 && ndone < 4) idle++;
        end
        req = 2'b00;
        checks++;
        if (ndone != 4 || order.size() != 4) begin
            errors++;
            $display("FAIL rr_count got done=%0d grants=%0d want 4 4", ndone, order.size());
        end else begin
            checks++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
                errors++;
                $display("FAIL rr_order got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]);
            end
        end
        checks++;
        if (idle != 3) begin
            errors++;
            $display("FAIL rr_idle_gaps got %0d want 3", idle);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_defer;
        bit ok;
        req = 2'b01; we = 2'b00; addr0 = 8'h30;
        push_exp(0, 1'b0, 8'h30, 8'h00);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        req = 2'b10; addr1 = 8'h07;
        push_exp(1, 1'b0, 8'h07, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b00 || done !== 2'b01 || rdata !== 8'h60) begin
            errors++;
            $display("FAIL defer_done got gnt=%b done=%b rdata=%h want 00 01 60", gnt, done, rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL defer_idle got gnt=%b busy=%b want 00 0", gnt, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL defer_grant got gnt=%b want 10", gnt);
        end
        req = 2'b00;
        wait_done(ok);
        checks++;
        if (!ok || done !== 2'b10 || rdata !== 8'h0E) begin
            errors++;
            $display("FAIL defer_dbg_done got ok=%0d done=%b rdata=%h want 1 10 0e", ok, done, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        req = 2'b01; we = 2'b01; addr0 = 8'h50; wdata0 = 8'h5A;
        push_exp(0, 1'b1, 8'h50, 8'h5A);
        @(posedge clk); #1;
        req = 2'b00;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rm_write_timeout got no done want done");
        end
        @(posedge clk); #1;
        // Read that will be dropped by reset during WAIT.
        req = 2'b01; we = 2'b00; addr0 = 8'h20;
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || mem_stage !== 1'b1 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rm_pre got busy=%b stage=%b rd=%b want 1 1 1", busy, mem_stage, mem_read);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, rdata, busy, mem_stage, mem_read, mem_write, mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL rm_async_clear got %h want 0",
                     {gnt, done, rdata, busy, mem_stage, mem_read, mem_write, mem_addr, mem_wdata});
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rm_no_done got done=%b busy=%b want 00 0", done, busy);
            end
        end
        req = 2'b01; we = 2'b00; addr0 = 8'h50;
        push_exp(0, 1'b0, 8'h50, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (gnt !== 2'b01 || mem_stage !== 1'b0) begin
            errors++;
            $display("FAIL rm_restart got gnt=%b stage=%b want 01 0", gnt, mem_stage);
        end
        req = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (mem_stage !== 1'b1) begin
            errors++;
            $display("FAIL rm_toggle got stage=%b want 1", mem_stage);
        end
        wait_done(ok);
        checks++;
        if (!ok || rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rm_readback got ok=%0d rdata=%h want 1 5a", ok, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_settle3;
        req3 = 2'b01; we3 = 2'b00; addr3 = 8'hFF;
        @(posedge clk); #1;
        checks++;
        if (gnt3 !== 2'b01) begin
            errors++;
            $display("FAIL s3_accept got gnt=%b want 01", gnt3);
        end
        req3 = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done3 !== 2'b00 || busy3 !== 1'b1) begin
                errors++;
                $display("FAIL s3_early cycle %0d got done=%b busy=%b want 00 1", k + 1, done3, busy3);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done3 !== 2'b01 || rdata3 !== 8'hFE) begin
            errors++;
            $display("FAIL s3_done got done=%b rdata=%h want 01 fe", done3, rdata3);
        end
        @(posedge clk); #1;
        checks++;
        if (done3 !== 2'b00 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL s3_idle got done=%b busy=%b want 00 0", done3, busy3);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'((2 * i) & 8'hFF);
            mem3[i]    = 8'((2 * i) & 8'hFF);
            ref_mem[i] = 8'((2 * i) & 8'hFF);
        end
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00; addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        req3 = 2'b00; we3 = 2'b00; addr3 = 8'h00; addr3b = 8'h00; wdata3 = 8'h00; wdata3b = 8'h00;

        test_reset();
        test_cpu_read();
        test_write_then_read();
        test_round_robin();
        test_busy_defer();
        test_reset_mid();
        test_settle3();

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
